// File: rtl/f_axil_master.sv
// Passive AXI4-lite master-port protocol monitor: outstanding counters plus sticky handshake-rule error flags.
// Define F_AXIL_MASTER_FORMAL_EN to also emit the rule set as assert/assume/cover properties.
module f_axil_master #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int STRB_WIDTH   = DATA_WIDTH / 8,
  parameter int OUTSTAND_MAX = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [ADDR_WIDTH-1:0]           m_axil_awaddr,
  input  logic [2:0]                      m_axil_awprot,
  input  logic                            m_axil_awvalid,
  input  logic                            m_axil_awready,
  input  logic [DATA_WIDTH-1:0]           m_axil_wdata,
  input  logic [STRB_WIDTH-1:0]           m_axil_wstrb,
  input  logic                            m_axil_wvalid,
  input  logic                            m_axil_wready,
  input  logic [1:0]                      m_axil_bresp,
  input  logic                            m_axil_bvalid,
  input  logic                            m_axil_bready,
  input  logic [ADDR_WIDTH-1:0]           m_axil_araddr,
  input  logic [2:0]                      m_axil_arprot,
  input  logic                            m_axil_arvalid,
  input  logic                            m_axil_arready,
  input  logic [DATA_WIDTH-1:0]           m_axil_rdata,
  input  logic [1:0]                      m_axil_rresp,
  input  logic                            m_axil_rvalid,
  input  logic                            m_axil_rready,
  output logic [$clog2(OUTSTAND_MAX)-1:0] f_axil_m_aw_outstanding,
  output logic [$clog2(OUTSTAND_MAX)-1:0] f_axil_m_w_outstanding,
  output logic [$clog2(OUTSTAND_MAX)-1:0] f_axil_m_ar_outstanding,
  output logic [7:0]                      f_axil_m_err,
  output logic                            f_axil_m_err_any
);

  localparam int CW = $clog2(OUTSTAND_MAX);
  localparam logic [CW-1:0] CNT_MAX = CW'(OUTSTAND_MAX - 1);

  logic awHs, wHs, arHs, bHs, rHs;
  logic chkEn;
  logic [7:0] viol;
  logic [CW-1:0] awCnt_q, awCnt_d, wCnt_q, wCnt_d, arCnt_q, arCnt_d;
  logic [7:0] err_q, err_d;
  logic errAny_q;
  logic pastValid_q, prevRst_q;

  logic [ADDR_WIDTH-1:0] prevAwAddr_q, prevArAddr_q;
  logic [2:0]            prevAwProt_q, prevArProt_q;
  logic [DATA_WIDTH-1:0] prevWData_q, prevRData_q;
  logic [STRB_WIDTH-1:0] prevWStrb_q;
  logic [1:0]            prevBResp_q, prevRResp_q;
  logic prevAwValid_q, prevAwReady_q, prevWValid_q, prevWReady_q, prevArValid_q, prevArReady_q;
  logic prevBValid_q, prevBReady_q, prevRValid_q, prevRReady_q;

  function automatic logic [CW-1:0] nextCount(input logic [CW-1:0] cur, input logic inc,
                                              input logic dec);
    logic [CW-1:0] n;
    n = cur;
    if (inc && !dec && cur != CNT_MAX) n = cur + 1'b1;
    else if (dec && !inc && cur != '0) n = cur - 1'b1;
    return n;
  endfunction

  always_comb begin
    awHs  = m_axil_awvalid & m_axil_awready & ~rst;
    wHs   = m_axil_wvalid  & m_axil_wready  & ~rst;
    arHs  = m_axil_arvalid & m_axil_arready & ~rst;
    bHs   = m_axil_bvalid  & m_axil_bready  & ~rst;
    rHs   = m_axil_rvalid  & m_axil_rready  & ~rst;
    chkEn = pastValid_q & ~prevRst_q & ~rst;

    awCnt_d = nextCount(awCnt_q, awHs, bHs);
    wCnt_d  = nextCount(wCnt_q, wHs, bHs);
    arCnt_d = nextCount(arCnt_q, arHs, rHs);

    // A stalled beat must stay valid with a frozen payload until accepted.
    viol    = '0;
    viol[0] = chkEn & prevAwValid_q & ~prevAwReady_q &
              (~m_axil_awvalid | (m_axil_awaddr != prevAwAddr_q) | (m_axil_awprot != prevAwProt_q));
    viol[1] = chkEn & prevWValid_q & ~prevWReady_q &
              (~m_axil_wvalid | (m_axil_wdata != prevWData_q) | (m_axil_wstrb != prevWStrb_q));
    viol[2] = chkEn & prevArValid_q & ~prevArReady_q &
              (~m_axil_arvalid | (m_axil_araddr != prevArAddr_q) | (m_axil_arprot != prevArProt_q));
    viol[3] = ~rst & prevRst_q & (m_axil_awvalid | m_axil_wvalid | m_axil_arvalid);
    viol[4] = chkEn & ((awCnt_q == CNT_MAX) | (wCnt_q == CNT_MAX) | (arCnt_q == CNT_MAX));
    viol[5] = chkEn & prevBValid_q & ~prevBReady_q &
              (~m_axil_bvalid | (m_axil_bresp != prevBResp_q));
    viol[6] = chkEn & prevRValid_q & ~prevRReady_q &
              (~m_axil_rvalid | (m_axil_rdata != prevRData_q) | (m_axil_rresp != prevRResp_q));
    viol[7] = chkEn & ((m_axil_bvalid & ((awCnt_q == '0) | (wCnt_q == '0))) |
                       (m_axil_rvalid & (arCnt_q == '0)));

    err_d = err_q | viol;
  end

  always_ff @(posedge clk) begin
    prevRst_q     <= rst;
    pastValid_q   <= ~rst;
    prevAwAddr_q  <= m_axil_awaddr;
    prevAwProt_q  <= m_axil_awprot;
    prevAwValid_q <= m_axil_awvalid;
    prevAwReady_q <= m_axil_awready;
    prevWData_q   <= m_axil_wdata;
    prevWStrb_q   <= m_axil_wstrb;
    prevWValid_q  <= m_axil_wvalid;
    prevWReady_q  <= m_axil_wready;
    prevBResp_q   <= m_axil_bresp;
    prevBValid_q  <= m_axil_bvalid;
    prevBReady_q  <= m_axil_bready;
    prevArAddr_q  <= m_axil_araddr;
    prevArProt_q  <= m_axil_arprot;
    prevArValid_q <= m_axil_arvalid;
    prevArReady_q <= m_axil_arready;
    prevRData_q   <= m_axil_rdata;
    prevRResp_q   <= m_axil_rresp;
    prevRValid_q  <= m_axil_rvalid;
    prevRReady_q  <= m_axil_rready;
    if (rst) begin
      awCnt_q  <= '0;
      wCnt_q   <= '0;
      arCnt_q  <= '0;
      err_q    <= '0;
      errAny_q <= 1'b0;
    end else begin
      awCnt_q  <= awCnt_d;
      wCnt_q   <= wCnt_d;
      arCnt_q  <= arCnt_d;
      err_q    <= err_d;
      errAny_q <= |err_d;
    end
  end

  assign f_axil_m_aw_outstanding = awCnt_q;
  assign f_axil_m_w_outstanding  = wCnt_q;
  assign f_axil_m_ar_outstanding = arCnt_q;
  assign f_axil_m_err            = err_q;
  assign f_axil_m_err_any        = errAny_q;

`ifdef F_AXIL_MASTER_FORMAL_EN
  // Master faults are proof obligations; slave faults constrain the environment.
  always @(posedge clk) begin
    if (!pastValid_q) asmInitReset: assume (rst);
    if (prevRst_q && !rst) asmNoRespAfterRst: assume (!m_axil_bvalid && !m_axil_rvalid);
    astAwStall:     assert (!viol[0]);
    astWStall:      assert (!viol[1]);
    astArStall:     assert (!viol[2]);
    astRstRecovery: assert (!viol[3]);
    astOverflow:    assert (!viol[4]);
    asmBStall:      assume (!viol[5]);
    asmRStall:      assume (!viol[6]);
    asmOrphanResp:  assume (!viol[7]);
    covAwHs:  cover (awHs);
    covWHs:   cover (wHs);
    covArHs:  cover (arHs);
    covBHs:   cover (bHs);
    covRHs:   cover (rHs);
    covAwCnt: cover (awCnt_q > '0);
    covWCnt:  cover (wCnt_q > '0);
    covArCnt: cover (arCnt_q > '0);
  end
`else
`endif

endmodule

// File: doc/f_axil_master.md
# f_axil_master

Protocol monitor for the master side of an AXI4-lite link. Passively observes all five channels, tracks outstanding AW/W/AR transactions, and raises sticky error flags on handshake-rule violations by either the master (request side) or the slave (response side). Instantiated alongside any block that drives an AXI-lite master port. Usable in simulation benches and, with the formal macro, as an assert/assume property set for proofs.

## Interface
- DATA_WIDTH, 32, data bus width in bits
- ADDR_WIDTH, 32, address bus width in bits
- STRB_WIDTH, DATA_WIDTH/8, write strobe width
- OUTSTAND_MAX, 64, outstanding-transaction bound; power of two, >= 4; CW = $clog2(OUTSTAND_MAX)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- m_axil_awaddr/awprot/awvalid/awready  in  ADDR_WIDTH/3/1/1  AW channel
- m_axil_wdata/wstrb/wvalid/wready  in  DATA_WIDTH/STRB_WIDTH/1/1  W channel
- m_axil_bresp/bvalid/bready  in  2/1/1  B channel
- m_axil_araddr/arprot/arvalid/arready  in  ADDR_WIDTH/3/1/1  AR channel
- m_axil_rdata/rresp/rvalid/rready  in  DATA_WIDTH/2/1/1  R channel
- f_axil_m_aw_outstanding  out  CW  accepted AW not yet answered on B
- f_axil_m_w_outstanding  out  CW  accepted W not yet answered on B
- f_axil_m_ar_outstanding  out  CW  accepted AR not yet answered on R
- f_axil_m_err  out  8  sticky error vector (bit map below)
- f_axil_m_err_any  out  1  OR of f_axil_m_err, registered with it

## Operation
- Handshakes: aw_hs = awvalid&awready, w_hs = wvalid&wready, ar_hs = arvalid&arready, b_hs = bvalid&bready, r_hs = rvalid&rready; all forced 0 while rst.
- Counters: AW/W +1 on own handshake without b_hs, -1 on b_hs without own handshake, hold on both/neither; AR likewise with r_hs. Increment saturates at OUTSTAND_MAX-1; decrement saturates at 0.
- Previous-cycle register: valid, ready and payload of every channel, plus prev_rst and past_valid (0 at reset/init, 1 after first clock).
- Checks active only when past_valid=1, prev_rst=0, rst=0:
  - bit0 AW stall: prev awvalid&!awready and (!awvalid or awaddr/awprot changed)
  - bit1 W stall: prev wvalid&!wready and (!wvalid or wdata/wstrb changed)
  - bit2 AR stall: prev arvalid&!arready and (!arvalid or araddr/arprot changed)
  - bit4 overflow: any counter == OUTSTAND_MAX-1
  - bit5 B stall (slave): prev bvalid&!bready and (!bvalid or bresp changed)
  - bit6 R stall (slave): prev rvalid&!rready and (!rvalid or rdata/rresp changed)
  - bit7 orphan response (slave): bvalid with aw or w counter == 0, or rvalid with ar counter == 0
- bit3 reset recovery: rst=0 and prev_rst=1 and any of awvalid/wvalid/arvalid.
- Bits 0-4 are master faults, 5-7 slave faults. Each bit sets and stays set until rst.

## Timing
- Reset values: all counters 0, f_axil_m_err 0, f_axil_m_err_any 0, past_valid 0.
- Counter updates at the edge sampling the handshake; visible next cycle.
- Error bit sets at the edge sampling the violation; visible one cycle later; err_any same cycle as the bit.
- Orphan check uses counter value before the current-cycle update (B/R may not share a cycle with the creating request handshake).
- Simultaneous request and response handshakes: counter holds, no error.
- rst mid-transaction: counters and errors clear next cycle; checks suppressed during rst and the cycle after (except bit3).

## Configuration
- F_AXIL_MASTER_FORMAL_EN defined: adds assume(rst) when !past_valid; each master-fault condition (bits 0-4) emitted as a named assert, each slave-fault condition (bits 5-7) as an assume; assume no bvalid/rvalid in the cycle after rst; covers on each handshake and on each counter > 0. Error outputs still produced.
- Undefined: no assert/assume/cover; pure synthesizable monitor with error outputs only.

## Test plan
- Reset, then AW(addr 0x10)+W handshakes in cycle 3, B handshake cycle 6 -> aw/w counters 0->1 at cycle 4, back to 0 at cycle 7; f_axil_m_err = 0.
- awvalid=1, awready=0 at addr 0x20, next cycle addr 0x24 -> f_axil_m_err = 0x01, err_any=1 one cycle later, remains after awvalid drops.
- bvalid=1 with aw counter 0 -> err bit7 (0x80); rvalid held with bready... rvalid=1, rready=0, rdata 0xA5 then 0x5A -> bit6 set.
- Issue 63 AR handshakes with no R (OUTSTAND_MAX=64) -> counter saturates at 63, bit4 set; one R handshake -> counter 62, bit4 stays.
- arvalid=1 in cycle right after rst deasserts -> bit3 set; assert rst mid-burst with counters at 3 -> all outputs 0 the next cycle.
- Same-cycle AR handshake and R handshake with ar counter 2 -> counter stays 2, no error.
